mul_approx_seq: RTL and testbench
=================================

MUL_APPROX_SEQ -- requirements
Module: mul_approx_seq

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 4..16.
REQ-002 Parameter TW, default 4: width of the TRUNC input; SHALL satisfy 2^TW > W.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 A  input  W  multiplicand, unsigned.
REQ-006 B  input  W  multiplier, unsigned.
REQ-007 TRUNC  input  TW  number of low result columns to truncate (K); values above W are clamped to W.
REQ-008 IN_VALID  input  1  A/B/TRUNC are valid.
REQ-009 IN_READY  output  1  block can accept an operation.
REQ-010 O  output  2W  approximate product, registered.
REQ-011 OUT_VALID  output  1  O holds a completed result.
REQ-012 OUT_READY  input  1  consumer accepts O.

Function
REQ-013 There SHALL be three states: IDLE, BUSY and DONE.
REQ-014 IN_READY SHALL be 1 in IDLE only; OUT_VALID SHALL be 1 in DONE only.
REQ-015 Accept: in IDLE with IN_VALID=1, the rising edge (E0) SHALL latch A, B and Kc=min(TRUNC,W), clear the accumulator, and enter BUSY.
REQ-016 While IN_READY=0, IN_VALID SHALL be ignored; no operation is queued.
REQ-017 BUSY step (one per edge): if the LSB of shifted-B is 1, accumulator += (A << i) with bits [Kc-1:0] forced to 0 (i = step index from 0); then shift B right by 1 and increment i.
REQ-018 Early termination: when shifted-B becomes 0 after a step, the same edge SHALL enter DONE; BUSY therefore lasts max(1, msb_index(B)+1) cycles, and latency from E0 to OUT_VALID is that count.
REQ-019 Compensation: on the edge entering DONE, if Kc>0 and the latched A!=0 and B!=0, add 2^(Kc-1); otherwise add nothing.
REQ-020 With Kc=0 the result SHALL equal the exact product A*B.
REQ-021 The accumulator is 2W bits; by construction no overflow occurs and no wrap handling is needed.
REQ-022 O SHALL update only on the edge entering DONE and SHALL hold stable while OUT_VALID=1.
REQ-023 In DONE with OUT_READY=1, the next edge SHALL return to IDLE; O keeps its last value and OUT_VALID falls.
REQ-024 There SHALL be no IDLE bypass: the earliest new accept is one cycle after the DONE->IDLE edge.
REQ-025 OUT_READY SHALL be ignored outside DONE.
REQ-026 Changes on A/B/TRUNC after E0 SHALL NOT affect the operation in flight.

Reset
REQ-027 RST_N=0 SHALL immediately force IDLE, O=0, OUT_VALID=0 and IN_READY=1, and clear the accumulator, step index and latched operands, regardless of state.
REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation; no result is produced after release.
REQ-029 The first accept SHALL be possible on the first rising edge after RST_N deasserts.

Verification (W=8, TW=4)
REQ-030 A=255, B=255, TRUNC=0 -> O=65025 (0xFE01); OUT_VALID rises 8 edges after E0.
REQ-031 A=0x0F, B=0x01, TRUNC=4 -> truncated sum 0, plus compensation 8 -> O=8; latency 1 cycle.
REQ-032 A=0, B=5, TRUNC=3 -> O=0 (no compensation); latency 3 cycles.
REQ-033 A=0xFF, B=0x80, TRUNC=12 (clamped to 8) -> 0x7F80 truncated to 0x7F00, plus 128 -> O=32640; latency 8 cycles.
REQ-034 Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> O and OUT_VALID stay stable, IN_READY stays 0, IN_VALID pulses are ignored; release -> IDLE on the next edge.
REQ-035 Pull RST_N low at BUSY step 3 of 255*255 -> outputs immediately at their reset values; a new op 3*7 with TRUNC=0 afterwards -> O=21, latency 3 cycles.

Source files
------------

// File: rtl/mul_approx_seq.sv
`default_nettype none
// ============================================================================
// mul_approx_seq : sequential shift-add multiplier with low-column truncation
//                  and half-LSB compensation, early exit on exhausted multiplier
// Revision 1.0
// ============================================================================
module mul_approx_seq #(
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TW-1:0]    trunc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*W-1:0]   o,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_sh;
  logic [KW-1:0]   kc;
  logic [IW-1:0]   idx;
  logic [2*W-1:0]  acc;
  logic            nz;

  logic [KW-1:0]   kc_in;
  logic [KW-1:0]   kc_m1;
  logic [2*W-1:0]  addend;
  logic [2*W-1:0]  acc_sum;
  logic [2*W-1:0]  comp;

  // TW is wide enough to hold W, so the clamp fits into KW bits
  assign kc_in  = (trunc > TW'(W)) ? KW'(W) : KW'(trunc);
  assign kc_m1  = kc - KW'(1);
  assign addend = ({{W{1'b0}}, a_q} << idx) & ({(2*W){1'b1}} << kc);
  assign acc_sum = b_sh[0] ? (acc + addend) : acc;
  assign comp   = ((kc != '0) && nz) ? ({{(2*W-1){1'b0}}, 1'b1} << kc_m1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= '0;
      a_q       <= '0;
      b_sh      <= '0;
      kc        <= '0;
      idx       <= '0;
      acc       <= '0;
      nz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_sh     <= b;
            kc       <= kc_in;
            idx      <= '0;
            acc      <= '0;
            nz       <= (a != '0) && (b != '0);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_sum;
          b_sh <= b_sh >> 1;
          idx  <= idx + IW'(1);
          // Exit as soon as no set multiplier bits remain after this step
          if (b_sh[W-1:1] == '0) begin
            o         <= acc_sum + comp;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_approx_seq.sv
`default_nettype none
// tb_mul_approx_seq : scoreboard bench with randomized operands and an
// arithmetic reference model of the truncated/compensated product.
`timescale 1ns/1ps
module tb_mul_approx_seq;

  localparam int W  = 8;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [TW-1:0]   trunc;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  o;
  logic            out_valid;
  logic            out_ready = 1'b1;

  mul_approx_seq #(.W(W), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .trunc     (trunc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int lat;
    int e0;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  bit   bp_hold  = 1'b0;
  bit   rand_ready = 1'b0;
  bit   seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Product as a sum of partial products, each with its low Kc columns dropped
  function automatic void ref_model(input int av, input int bv, input int tv,
                                    output int p, output int lat);
    int kc;
    kc  = (tv > W) ? W : tv;
    p   = 0;
    lat = 1;
    for (int j = 0; j < W; j++) begin
      if (((bv >> j) & 1) == 1) begin
        p   += ((av << j) >> kc) << kc;
        lat = j + 1;
      end
    end
    if (kc > 0 && av != 0 && bv != 0) p += 1 << (kc - 1);
  endfunction

  // Consumer readiness changes a little after the falling edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      out_ready = bp_hold ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  // Monitor: one comparison set per presented result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check("spurious_result", int'(o), -1);
        end else begin
          e = sb.pop_front();
          check("product", int'(o), e.p);
          check("latency", cyc - e.e0, e.lat);
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  task automatic do_op(input int av, input int bv, input int tv, input bit no_wait);
    int   guard;
    exp_t e;
    guard = 0;
    if (!no_wait) @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    a        = W'(av);
    b        = W'(bv);
    trunc    = TW'(tv);
    in_valid = 1'b1;
    ref_model(av, bv, tv, e.p, e.lat);
    e.e0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    trunc    = TW'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int   guard;
    logic [2*W-1:0] cap;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    trunc    = '0;

    repeat (3) @(negedge clk);
    check("reset_o", int'(o), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    do_op(255, 255, 0, 1'b0);
    do_op(8'h0F, 8'h01, 4, 1'b0);
    do_op(0, 5, 3, 1'b0);
    do_op(8'hFF, 8'h80, 12, 1'b0);
    do_op(77, 0, 5, 1'b0);
    do_op(1, 1, 8, 1'b0);
    drain();

    rand_ready = 1'b1;
    repeat (40) do_op(int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(15)), 1'b0);
    drain();
    rand_ready = 1'b0;

    // Backpressure: result must hold and new requests must be refused
    bp_hold = 1'b1;
    do_op(8'h12, 8'h34, 2, 1'b0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    cap = o;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_o_stable", int'(o), int'(cap));
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_in_ready_low", int'(in_ready), 0);
      in_valid = k[0];
      a        = W'($urandom);
      b        = W'($urandom);
    end
    in_valid = 1'b0;
    bp_hold  = 1'b0;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_o_kept", int'(o), int'(cap));
    drain();

    // Asynchronous reset in the middle of a long operation
    do_op(255, 255, 0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_o", int'(o), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    check("abort_hold_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    do_op(3, 7, 0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", tot_cnt);
    $fatal(1);
  end

endmodule
`default_nettype wire
